// File: rtl/cci_mpf_prim_fifo1_serializer.sv
// Serializer that drains a single-entry FIFO stage (first/notEmpty/deq_en)
// and replays each wide word as N_BEATS narrow beats on a valid/ready stream.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   in_first       head word of the upstream FIFO
//   in_notEmpty    upstream FIFO holds a word
//   in_deq_en      dequeue strobe to the upstream FIFO (combinational)
//   out_data       current beat
//   out_valid      beat valid
//   out_ready      consumer accepts the beat
//   out_sop        current beat is beat 0 of its word
//   out_eop        current beat is the last beat of its word
//   busy           a word is held (same as out_valid)
module cci_mpf_prim_fifo1_serializer #(
    parameter int unsigned N_DATA_BITS = 512,
    parameter int unsigned N_BEAT_BITS = 128,
    parameter bit          LSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_DATA_BITS-1:0] in_first,
    input  logic                   in_notEmpty,
    output logic                   in_deq_en,
    output logic [N_BEAT_BITS-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   busy
);

    localparam int unsigned N_BEATS  = N_DATA_BITS / N_BEAT_BITS;
    localparam int unsigned CNT_BITS = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(N_BEATS - 1);

    if ((N_DATA_BITS % N_BEAT_BITS) != 0 || N_BEATS == 0) begin : g_bad_width
        $fatal(1, "N_BEAT_BITS must divide N_DATA_BITS exactly");
    end

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    beat_q, beat_d;
    logic [N_DATA_BITS-1:0] data_q;
    logic                   last_beat;
    logic                   accept;
    logic [CNT_BITS-1:0]    slice_idx;

    always_comb begin
        out_valid = (state_q == StSend);
        busy      = out_valid;
        last_beat = (beat_q == LAST_BEAT);
        accept    = out_valid && out_ready;
        // Gated by reset_n so no dequeue is requested while held in reset.
        in_deq_en = reset_n && in_notEmpty && ((state_q == StIdle) || (accept && last_beat));
        out_sop   = (beat_q == '0);
        out_eop   = last_beat;
        slice_idx = LSB_FIRST ? beat_q : (LAST_BEAT - beat_q);

        state_d = state_q;
        beat_d  = beat_q;
        if (in_deq_en) begin
            // Covers both the idle fetch and the back-to-back reload on the last beat.
            state_d = StSend;
            beat_d  = '0;
        end else if (accept) begin
            if (last_beat) begin
                state_d = StIdle;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    if (N_BEATS == 1) begin : g_single
        assign out_data = data_q;
    end else begin : g_multi
        logic [N_BEATS-1:0][N_BEAT_BITS-1:0] slices;
        assign slices   = data_q;
        assign out_data = slices[slice_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (in_deq_en) begin
                data_q <= in_first;
            end
        end
    end

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_data) && $stable(out_sop) && $stable(out_eop)))
        else $fatal(1, "out_valid/out_data changed without a handshake");

    a_deq_needs_word: assert property (@(posedge clk) disable iff (!reset_n)
        in_deq_en |-> in_notEmpty)
        else $fatal(1, "in_deq_en asserted while in_notEmpty=0");
`endif

endmodule
